// File: rtl/mac_host_seq.sv
// mac_host_seq: host-side command sequencer for the serial MAC core.
//
// It accepts CLEAR / MAC / READ / NOP operations over a valid/ready handshake.
// For each one it plays out the core's cmd / gated-clock / serial-bit sequence.
// READ returns the 2*WIDTH-bit accumulator in parallel.
//
// Ports
//   clk, reset            system clock; synchronous active-high reset
//   op_valid / op_ready   operation handshake (ready is high only while idle)
//   op_code               0=CLEAR 1=MAC 2=READ 3=NOP
//   op_a, op_b            operands, captured on accept
//   rd_valid, rd_data     one-cycle pulse and value of the last READ
//   mac_cmd, mac_clk      core command and gated core clock
//   mac_io_out/oe/in      shared data wire (tri-state is built one level up)
//
// Every output is registered. mac_cmd only changes while mac_clk is low, so
// the core never sees a command change around a rising edge.
module mac_host_seq #(
  parameter int WIDTH = 16,
  parameter int HALF  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 op_valid,
  output logic                 op_ready,
  input  logic [1:0]           op_code,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  output logic                 rd_valid,
  output logic [2*WIDTH-1:0]   rd_data,
  output logic [1:0]           mac_cmd,
  output logic                 mac_clk,
  output logic                 mac_io_out,
  output logic                 mac_io_oe,
  input  logic                 mac_io_in
);

  localparam int AW = 2 * WIDTH;
  localparam int HW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int BW = $clog2(AW);
  localparam logic [HW-1:0] HALF_LAST = HW'(HALF - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(AW - 1);

  localparam logic [1:0] CMD_CLEAR = 2'b00;
  localparam logic [1:0] CMD_SHIFT = 2'b01;
  localparam logic [1:0] CMD_LOAD  = 2'b10;
  localparam logic [1:0] CMD_READ  = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SLOT_LO, S_SLOT_HI, S_TAIL} state_t;
  typedef enum logic [1:0] {OP_CLEAR = 2'd0, OP_MAC = 2'd1, OP_READ = 2'd2, OP_NOP = 2'd3} op_t;

  state_t          state_q, state_d;
  op_t             op_q, op_d;
  logic            load_q, load_d;     // MAC is in its load phase (after the shift slots)
  logic [HW-1:0]   half_q, half_d;     // cycle count inside the current half slot
  logic [BW-1:0]   bit_q, bit_d;       // slot index inside the current phase
  logic [AW-1:0]   shreg_q, shreg_d;   // outgoing operand bits, LSB goes next
  logic [AW-1:0]   shadow_q, shadow_d; // incoming accumulator bits, MSB first
  logic [AW-1:0]   rd_data_q, rd_data_d;
  logic            rd_valid_q, rd_valid_d;
  logic            op_ready_q, op_ready_d;
  logic [1:0]      mac_cmd_q, mac_cmd_d;
  logic            mac_clk_q, mac_clk_d;
  logic            io_out_q, io_out_d;
  logic            io_oe_q, io_oe_d;

  logic            shift_phase;
  logic            last_slot;

  always_comb begin
    // NOTE: every *_d starts from its held value so no path through this block infers a latch.
    state_d    = state_q;
    op_d       = op_q;
    load_d     = load_q;
    half_d     = half_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    shadow_d   = shadow_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    mac_cmd_d  = mac_cmd_q;
    io_out_d   = io_out_q;
    io_oe_d    = io_oe_q;

    shift_phase = (op_q == OP_MAC) && !load_q;
    // Shift and read phases run AW slots; clear and load run a single slot.
    last_slot   = (shift_phase || (op_q == OP_READ)) ? (bit_q == BIT_LAST) : 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          op_d    = op_t'(op_code);
          load_d  = 1'b0;
          bit_d   = '0;
          half_d  = '0;
          shreg_d = {op_a, op_b};
          state_d = S_SETUP;
          unique case (op_t'(op_code))
            OP_CLEAR: mac_cmd_d = CMD_CLEAR;
            OP_READ: begin
              mac_cmd_d = CMD_READ;
              io_oe_d   = 1'b0;
            end
            default:  mac_cmd_d = CMD_SHIFT;  // MAC, and NOP keeps the idle command
          endcase
        end
      end

      S_SETUP: begin
        if (op_q == OP_NOP) begin
          state_d = S_TAIL;
        end else begin
          state_d  = S_SLOT_LO;
          half_d   = '0;
          io_out_d = shift_phase & shreg_q[0];
          if (shift_phase) shreg_d = shreg_q >> 1;
        end
      end

      S_SLOT_LO: begin
        if (half_q == HALF_LAST) begin
          state_d = S_SLOT_HI;
          half_d  = '0;
          // Last low cycle: the core's bit is stable and the rising edge is next.
          if (op_q == OP_READ) shadow_d = {shadow_q[AW-2:0], mac_io_in};
        end else begin
          half_d = half_q + HW'(1);
        end
      end

      S_SLOT_HI: begin
        if (half_q == HALF_LAST) begin
          half_d = '0;
          if (!last_slot) begin
            bit_d    = bit_q + BW'(1);
            state_d  = S_SLOT_LO;
            io_out_d = shift_phase & shreg_q[0];
            if (shift_phase) shreg_d = shreg_q >> 1;
          end else if (shift_phase) begin
            state_d   = S_SETUP;
            load_d    = 1'b1;
            bit_d     = '0;
            mac_cmd_d = CMD_LOAD;
          end else begin
            state_d = S_TAIL;
          end
        end else begin
          half_d = half_q + HW'(1);
        end
      end

      S_TAIL: begin
        state_d   = S_IDLE;
        mac_cmd_d = CMD_SHIFT;
        io_oe_d   = 1'b1;
        io_out_d  = 1'b0;
        if (op_q == OP_READ) begin
          rd_data_d  = shadow_q;
          rd_valid_d = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    mac_clk_d  = (state_d == S_SLOT_HI);
    op_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= OP_NOP;
      load_q     <= 1'b0;
      half_q     <= '0;
      bit_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      op_ready_q <= 1'b1;
      mac_cmd_q  <= CMD_SHIFT;
      mac_clk_q  <= 1'b0;
      io_out_q   <= 1'b0;
      io_oe_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      load_q     <= load_d;
      half_q     <= half_d;
      bit_q      <= bit_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      op_ready_q <= op_ready_d;
      mac_cmd_q  <= mac_cmd_d;
      mac_clk_q  <= mac_clk_d;
      io_out_q   <= io_out_d;
      io_oe_q    <= io_oe_d;
    end
  end

  // NOTE: the shift registers have no reset; each op fully reloads or refills them before use.
  always_ff @(posedge clk) begin
    shreg_q  <= shreg_d;
    shadow_q <= shadow_d;
  end

  assign op_ready   = op_ready_q;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;
  assign mac_cmd    = mac_cmd_q;
  assign mac_clk    = mac_clk_q;
  assign mac_io_out = io_out_q;
  assign mac_io_oe  = io_oe_q;

endmodule

// File: tb/tb_mac_host_seq.sv
// Self-checking bench for mac_host_seq.
// The bench contains a behavioural model of the serial MAC core on the shared wire.
// A per-op cycle schedule gives the expected sequencer outputs.
// An arithmetic accumulator model gives the expected READ results.
module tb_mac_host_seq;

  localparam int W    = 16;
  localparam int HALF = 1;
  localparam int AW   = 2 * W;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            op_valid = 1'b0;
  logic            op_ready;
  logic [1:0]      op_code = 2'd3;
  logic [W-1:0]    op_a = '0;
  logic [W-1:0]    op_b = '0;
  logic            rd_valid;
  logic [AW-1:0]   rd_data;
  logic [1:0]      mac_cmd;
  logic            mac_clk;
  logic            mac_io_out;
  logic            mac_io_oe;
  logic            mac_io_in;

  always #5 clk = ~clk;

  mac_host_seq #(.WIDTH(W), .HALF(HALF)) dut (
    .clk        (clk),
    .reset      (reset),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_code    (op_code),
    .op_a       (op_a),
    .op_b       (op_b),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .mac_cmd    (mac_cmd),
    .mac_clk    (mac_clk),
    .mac_io_out (mac_io_out),
    .mac_io_oe  (mac_io_oe),
    .mac_io_in  (mac_io_in)
  );

  // ---------------- core model (environment) ----------------
  logic [AW-1:0] core_acc = 32'hDEAD_BEEF;  // undefined until the first CLEAR
  logic [AW-1:0] core_sr  = '0;
  logic          core_prev_clk = 1'b0;
  logic [1:0]    cmd_at_rise = 2'b01;
  int            rises = 0;
  logic [1:0]    rise_log[$];

  // Shared wire: host drives while oe=1, otherwise the core presents its accumulator MSB.
  assign mac_io_in = mac_io_oe ? mac_io_out : core_acc[AW-1];

  // ---------------- expected-value model ----------------
  typedef struct packed {
    logic [1:0]    cmd;
    logic          mclk;
    logic          oe;
    logic          rdy;
    logic          io_chk;
    logic          io;
    logic          rdv;
    logic [AW-1:0] rdd;
  } entry_t;

  entry_t        exp_q[$];
  logic [AW-1:0] acc_m  = '0;
  logic [AW-1:0] exp_rd = '0;
  bit            cur_idle = 1'b1;
  int            rdv_cnt = 0;
  int            n_checks = 0;
  int            n_fail = 0;

  task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic entry_t mk(input logic [1:0] cmd, input logic mclk, input logic oe,
                                input logic io_chk, input logic io);
    entry_t e;
    e.cmd = cmd; e.mclk = mclk; e.oe = oe; e.rdy = 1'b0;
    e.io_chk = io_chk; e.io = io; e.rdv = 1'b0; e.rdd = '0;
    return e;
  endfunction

  function automatic entry_t idle_e();
    entry_t e;
    e = mk(2'b01, 1'b0, 1'b1, 1'b1, 1'b0);
    e.rdy = 1'b1;
    return e;
  endfunction

  task automatic push_slot(input logic [1:0] cmd, input logic oe, input logic io_chk, input logic io);
    for (int i = 0; i < HALF; i++) exp_q.push_back(mk(cmd, 1'b0, oe, io_chk, io));
    for (int i = 0; i < HALF; i++) exp_q.push_back(mk(cmd, 1'b1, oe, io_chk, io));
  endtask

  // Expected per-cycle outputs of one op, starting the cycle after the accept edge.
  task automatic push_schedule(input logic [1:0] code, input logic [W-1:0] a, input logic [W-1:0] b);
    entry_t e;
    case (code)
      2'd0: begin
        exp_q.push_back(mk(2'b00, 1'b0, 1'b1, 1'b0, 1'b0));
        push_slot(2'b00, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(mk(2'b00, 1'b0, 1'b1, 1'b0, 1'b0));
        acc_m = '0;
      end
      2'd1: begin
        exp_q.push_back(mk(2'b01, 1'b0, 1'b1, 1'b0, 1'b0));
        for (int k = 0; k < AW; k++) push_slot(2'b01, 1'b1, 1'b1, (k < W) ? b[k] : a[k-W]);
        exp_q.push_back(mk(2'b10, 1'b0, 1'b1, 1'b0, 1'b0));
        push_slot(2'b10, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(mk(2'b10, 1'b0, 1'b1, 1'b0, 1'b0));
        acc_m = acc_m + (AW'(a) * AW'(b));
      end
      2'd2: begin
        exp_q.push_back(mk(2'b11, 1'b0, 1'b0, 1'b0, 1'b0));
        for (int k = 0; k < AW; k++) push_slot(2'b11, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(mk(2'b11, 1'b0, 1'b0, 1'b0, 1'b0));
        e = idle_e();
        e.rdv = 1'b1;
        e.rdd = acc_m;
        exp_q.push_back(e);
      end
      default: begin
        exp_q.push_back(mk(2'b01, 1'b0, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(mk(2'b01, 1'b0, 1'b1, 1'b0, 1'b0));
      end
    endcase
  endtask

  task automatic core_step();
    if (mac_clk && !core_prev_clk) begin
      cmd_at_rise = mac_cmd;
      rises++;
      if (rise_log.size() == 0 || rise_log[rise_log.size()-1] != mac_cmd) rise_log.push_back(mac_cmd);
      case (mac_cmd)
        2'b00: core_acc = '0;
        2'b01: core_sr  = {mac_io_in, core_sr[AW-1:1]};
        2'b10: core_acc = core_acc + (AW'(core_sr[AW-1:W]) * AW'(core_sr[W-1:0]));
        default: core_acc = {core_acc[AW-2:0], core_acc[AW-1]};
      endcase
    end
    if (mac_clk) check("cmd_stable_while_clk_high", AW'(mac_cmd), AW'(cmd_at_rise));
    check("bus_contention", AW'(mac_io_oe && (mac_cmd == 2'b11)), '0);
    core_prev_clk = mac_clk;
  endtask

  task automatic compare_cycle();
    entry_t e;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = idle_e();
    cur_idle = e.rdy;
    if (e.rdv) exp_rd = e.rdd;
    check("mac_cmd",  AW'(mac_cmd),   AW'(e.cmd));
    check("mac_clk",  AW'(mac_clk),   AW'(e.mclk));
    check("mac_io_oe", AW'(mac_io_oe), AW'(e.oe));
    check("op_ready", AW'(op_ready),  AW'(e.rdy));
    check("rd_valid", AW'(rd_valid),  AW'(e.rdv));
    check("rd_data",  rd_data,        exp_rd);
    if (e.io_chk) check("mac_io_out", AW'(mac_io_out), AW'(e.io));
    if (rd_valid) rdv_cnt++;
  endtask

  // One clock: sample on the falling edge, then move inputs just after it.
  task automatic tick();
    @(negedge clk);
    core_step();
    compare_cycle();
    #1;
  endtask

  task automatic issue(input logic [1:0] code, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit hold, input int exp_lat, input string name);
    int guard;
    int lat;
    guard = 0;
    while (!cur_idle && guard < 2000) begin
      tick();
      guard++;
    end
    check({name, "_wait_idle"}, AW'(cur_idle), AW'(1));
    op_code  = code;
    op_a     = a;
    op_b     = b;
    op_valid = 1'b1;
    push_schedule(code, a, b);
    tick();
    lat = 0;
    if (!hold) op_valid = 1'b0;
    while (!op_ready && lat < 2000) begin
      if (hold) begin
        op_a    = W'($urandom);
        op_b    = W'($urandom);
        op_code = 2'($urandom);
        if (exp_q.size() == 0) op_valid = 1'b0;
      end
      tick();
      lat++;
    end
    op_valid = 1'b0;
    check({name, "_latency"}, AW'(lat), AW'(exp_lat));
  endtask

  initial begin
    int r0;
    repeat (3) @(negedge clk);
    tick();
    tick();
    check("rst_op_ready", AW'(op_ready),   AW'(1));
    check("rst_rd_data",  rd_data,         '0);
    check("rst_mac_cmd",  AW'(mac_cmd),    AW'(2'b01));
    check("rst_mac_clk",  AW'(mac_clk),    '0);
    check("rst_oe",       AW'(mac_io_oe),  AW'(1));
    check("rst_io_out",   AW'(mac_io_out), '0);
    reset = 1'b0;

    // CLEAR then READ -> 0, one rd_valid pulse.
    r0 = rdv_cnt;
    issue(2'd0, '0, '0, 1'b0, 4, "clear0");
    issue(2'd2, '0, '0, 1'b0, 66, "read0");
    check("read0_data",  rd_data, 32'h0000_0000);
    check("read0_rdv",   AW'(rd_valid), AW'(1));
    tick();
    check("read0_pulses", AW'(rdv_cnt - r0), AW'(1));

    // CLEAR; MAC 3*5; READ -> 0xF, with the command order 00/01/10/11.
    rise_log.delete();
    issue(2'd0, '0, '0, 1'b0, 4, "clear1");
    issue(2'd1, 16'd3, 16'd5, 1'b0, 69, "mac_3x5");
    issue(2'd2, '0, '0, 1'b0, 66, "read1");
    check("read1_data", rd_data, 32'h0000_000F);
    check("cmd_seq_len", AW'(rise_log.size()), AW'(4));
    for (int i = 0; i < rise_log.size() && i < 4; i++) check("cmd_seq", AW'(rise_log[i]), AW'(i));

    // Wrap-around accumulation.
    issue(2'd0, '0, '0, 1'b0, 4, "clear2");
    issue(2'd1, 16'hFFFF, 16'hFFFF, 1'b0, 69, "mac_ffff_a");
    issue(2'd1, 16'hFFFF, 16'hFFFF, 1'b0, 69, "mac_ffff_b");
    issue(2'd2, '0, '0, 1'b0, 66, "read2");
    check("read2_data", rd_data, 32'hFFFC_0002);

    // READ leaves the accumulator intact.
    issue(2'd0, '0, '0, 1'b0, 4, "clear3");
    issue(2'd1, 16'h1234, 16'h0010, 1'b0, 69, "mac_1234");
    issue(2'd2, '0, '0, 1'b0, 66, "read3a");
    check("read3a_data", rd_data, 32'h0001_2340);
    issue(2'd2, '0, '0, 1'b0, 66, "read3b");
    check("read3b_data", rd_data, 32'h0001_2340);

    // Reset in the middle of a MAC.
    op_code  = 2'd1;
    op_a     = 16'h1111;
    op_b     = 16'h2222;
    op_valid = 1'b1;
    push_schedule(2'd1, 16'h1111, 16'h2222);
    tick();
    op_valid = 1'b0;
    repeat (29) tick();
    reset = 1'b1;
    exp_q.delete();
    exp_rd = '0;
    r0 = rdv_cnt;
    tick();
    check("midrst_op_ready", AW'(op_ready), AW'(1));
    check("midrst_mac_clk",  AW'(mac_clk),  '0);
    check("midrst_mac_cmd",  AW'(mac_cmd),  AW'(2'b01));
    check("midrst_rd_valid", AW'(rd_valid), '0);
    check("midrst_rd_data",  rd_data,       '0);
    reset = 1'b0;
    issue(2'd0, '0, '0, 1'b0, 4, "clear4");
    issue(2'd2, '0, '0, 1'b0, 66, "read4");
    check("read4_data", rd_data, 32'h0000_0000);
    check("midrst_pulses", AW'(rdv_cnt - r0), AW'(1));

    // op_valid held high with changing operands during a MAC; then a NOP.
    issue(2'd0, '0, '0, 1'b0, 4, "clear5");
    issue(2'd1, 16'd7, 16'd9, 1'b1, 69, "mac_hold");
    issue(2'd2, '0, '0, 1'b0, 66, "read5");
    check("read5_data", rd_data, 32'h0000_003F);
    r0 = rises;
    issue(2'd3, '0, '0, 1'b0, 2, "nop");
    check("nop_no_clk_edges", AW'(rises - r0), '0);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
